// File: rtl/register_map.sv
// Architectural register file with rename state (committed data, youngest pending
// producer tag, ready bit) answering the ROB's retire, dispatch and source-lookup ports.

module register_map_rd_port #(
    parameter int DATA_WIDTH     = 32,
    parameter int TAG_WIDTH      = 6,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_REGS       = 2**REG_ADDR_WIDTH
) (
    input  logic [REG_ADDR_WIDTH-1:0]             rsrc,
    input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]   data_file,
    input  logic [NUM_REGS-1:0][TAG_WIDTH-1:0]    tag_file,
    input  logic [NUM_REGS-1:0]                   rdy_file,
    output logic [DATA_WIDTH-1:0]                 data,
    output logic [TAG_WIDTH-1:0]                  tag,
    output logic                                  rdy
);
    // r0 is forced here so its stored entry never matters.
    always_comb begin
        data = data_file[rsrc];
        tag  = tag_file[rsrc];
        rdy  = rdy_file[rsrc];
        if (rsrc == '0) begin
            data = '0;
            tag  = '0;
            rdy  = 1'b1;
        end
    end
endmodule

module register_map #(
    parameter int DATA_WIDTH     = 32,
    parameter int ROB_DEPTH      = 64,
    parameter int REG_ADDR_WIDTH = 5,
    localparam int TAG_WIDTH     = $clog2(ROB_DEPTH),
    localparam int NUM_REGS      = 2**REG_ADDR_WIDTH,
    localparam int NUM_PORTS     = 2
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     i_flush,
    input  logic                                     dest_wr_en,
    input  logic [REG_ADDR_WIDTH-1:0]                dest_wr_rdest,
    input  logic [TAG_WIDTH-1:0]                     dest_wr_tag,
    input  logic [DATA_WIDTH-1:0]                    dest_wr_data,
    input  logic                                     tag_wr_en,
    input  logic [REG_ADDR_WIDTH-1:0]                tag_wr_rdest,
    input  logic [TAG_WIDTH-1:0]                     tag_wr_tag,
    input  logic [NUM_PORTS-1:0][REG_ADDR_WIDTH-1:0] lookup_rsrc,
    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]     lookup_data,
    output logic [NUM_PORTS-1:0][TAG_WIDTH-1:0]      lookup_tag,
    output logic [NUM_PORTS-1:0]                     lookup_rdy
);
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] data_q;
    logic [NUM_REGS-1:0][TAG_WIDTH-1:0]  tag_q;
    logic [NUM_REGS-1:0]                 rdy_q;

    logic dest_hit, tag_hit, retire_clears;
    assign dest_hit      = dest_wr_en && (dest_wr_rdest != '0);
    assign tag_hit       = tag_wr_en && (tag_wr_rdest != '0);
    // Only the youngest pending producer may mark the register ready again.
    assign retire_clears = !rdy_q[dest_wr_rdest] && (tag_q[dest_wr_rdest] == dest_wr_tag);

    // Later assignments win: flush beats dispatch, dispatch beats retire on the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            tag_q  <= '0;
            rdy_q  <= '1;
        end else begin
            if (dest_hit) begin
                data_q[dest_wr_rdest] <= dest_wr_data;
                if (retire_clears)
                    rdy_q[dest_wr_rdest] <= 1'b1;
            end
            if (i_flush) begin
                tag_q <= '0;
                rdy_q <= '1;
            end else if (tag_hit) begin
                tag_q[tag_wr_rdest] <= tag_wr_tag;
                rdy_q[tag_wr_rdest] <= 1'b0;
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        register_map_rd_port #(
            .DATA_WIDTH    (DATA_WIDTH),
            .TAG_WIDTH     (TAG_WIDTH),
            .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
            .NUM_REGS      (NUM_REGS)
        ) u_rd (
            .rsrc     (lookup_rsrc[p]),
            .data_file(data_q),
            .tag_file (tag_q),
            .rdy_file (rdy_q),
            .data     (lookup_data[p]),
            .tag      (lookup_tag[p]),
            .rdy      (lookup_rdy[p])
        );
    end
endmodule

// File: tb/tb_register_map.sv
// Directed bench for register_map: stimulus queues expected lookups, a negedge monitor checks them.

module tb_register_map;
    localparam int DW = 32;
    localparam int TW = 6;
    localparam int AW = 5;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   i_flush;
    logic                   dest_wr_en;
    logic [AW-1:0]          dest_wr_rdest;
    logic [TW-1:0]          dest_wr_tag;
    logic [DW-1:0]          dest_wr_data;
    logic                   tag_wr_en;
    logic [AW-1:0]          tag_wr_rdest;
    logic [TW-1:0]          tag_wr_tag;
    logic [1:0][AW-1:0]     lookup_rsrc;
    logic [1:0][DW-1:0]     lookup_data;
    logic [1:0][TW-1:0]     lookup_tag;
    logic [1:0]             lookup_rdy;

    register_map #(.DATA_WIDTH(DW), .ROB_DEPTH(64), .REG_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .i_flush(i_flush),
        .dest_wr_en(dest_wr_en), .dest_wr_rdest(dest_wr_rdest),
        .dest_wr_tag(dest_wr_tag), .dest_wr_data(dest_wr_data),
        .tag_wr_en(tag_wr_en), .tag_wr_rdest(tag_wr_rdest), .tag_wr_tag(tag_wr_tag),
        .lookup_rsrc(lookup_rsrc), .lookup_data(lookup_data),
        .lookup_tag(lookup_tag), .lookup_rdy(lookup_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        int            port;
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
        logic          rdy;
        string         name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   stim_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: everything queued during this cycle is checked at its negedge.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            if (e.cyc != cyc || lookup_data[e.port] !== e.data ||
                lookup_tag[e.port] !== e.tag || lookup_rdy[e.port] !== e.rdy) begin
                n_err++;
                $display("FAIL %s port%0d: got data=%h tag=%0d rdy=%b, want data=%h tag=%0d rdy=%b",
                         e.name, e.port, lookup_data[e.port], lookup_tag[e.port],
                         lookup_rdy[e.port], e.data, e.tag, e.rdy);
            end
        end
    end

    task automatic look(input int p, input logic [AW-1:0] r, input logic [DW-1:0] d,
                        input logic [TW-1:0] t, input logic rd, input string nm);
        exp_t e;
        lookup_rsrc[p] = r;
        e.cyc = cyc; e.port = p; e.data = d; e.tag = t; e.rdy = rd; e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic twr(input logic [AW-1:0] r, input logic [TW-1:0] t);
        tag_wr_en = 1'b1; tag_wr_rdest = r; tag_wr_tag = t;
    endtask

    task automatic dwr(input logic [AW-1:0] r, input logic [TW-1:0] t, input logic [DW-1:0] d);
        dest_wr_en = 1'b1; dest_wr_rdest = r; dest_wr_tag = t; dest_wr_data = d;
    endtask

    // Advance to just after the next posedge and drop all strobes.
    task automatic tick();
        @(posedge clk);
        #1;
        i_flush = 1'b0; tag_wr_en = 1'b0; dest_wr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; i_flush = 1'b0; dest_wr_en = 1'b0; tag_wr_en = 1'b0;
        dest_wr_rdest = '0; dest_wr_tag = '0; dest_wr_data = '0;
        tag_wr_rdest = '0; tag_wr_tag = '0; lookup_rsrc = '0;
        tick();
        // Held in reset: a dispatch to r5 is overridden.
        twr(5, 1);
        look(0, 5, 0, 0, 1, "reset_r5");
        look(1, 0, 0, 0, 1, "reset_r0");
        tick();
        rst = 1'b0;
        look(0, 5, 0, 0, 1, "reset_beats_tagwr");
        tick();

        // Rename then matching retire.
        twr(3, 7);
        tick();
        look(0, 3, 0, 7, 0, "r3_pending");
        dwr(3, 7, 32'hDEADBEEF);
        tick();
        look(0, 3, 32'hDEADBEEF, 7, 1, "r3_retired");
        tick();

        // Older retire must not clear a younger pending writer.
        twr(4, 2);
        tick();
        twr(4, 9);
        look(0, 4, 0, 2, 0, "r4_first_tag");
        tick();
        dwr(4, 2, 32'h11);
        look(1, 4, 0, 9, 0, "r4_second_tag");
        tick();
        look(0, 4, 32'h11, 9, 0, "r4_stale_retire");
        dwr(4, 9, 32'h22);
        tick();
        look(0, 4, 32'h22, 9, 1, "r4_young_retire");
        tick();

        // Same-cycle dispatch and retire on r6: dispatch wins tag/rdy.
        twr(6, 5);
        tick();
        look(0, 6, 0, 5, 0, "r6_pending");
        twr(6, 12);
        dwr(6, 5, 32'h33);
        tick();
        look(0, 6, 32'h33, 12, 0, "r6_collision");
        look(1, 6, 32'h33, 12, 0, "r6_same_idx_p1");
        tick();

        // Different registers in the same cycle.
        twr(9, 6);
        dwr(10, 0, 32'h77);
        tick();
        look(0, 9, 0, 6, 0, "r9_indep");
        look(1, 10, 32'h77, 0, 1, "r10_indep");
        tick();

        // Flush discards rename state, ignores dispatch, keeps data and retire data.
        dwr(1, 0, 32'hAA);
        tick();
        twr(1, 1);
        look(0, 1, 32'hAA, 0, 1, "r1_data");
        tick();
        twr(2, 2);
        look(0, 1, 32'hAA, 1, 0, "r1_pending");
        tick();
        i_flush = 1'b1;
        twr(7, 3);
        dwr(8, 0, 32'h55);
        look(0, 2, 0, 2, 0, "r2_pending");
        tick();
        look(0, 1, 32'hAA, 0, 1, "flush_r1");
        look(1, 2, 0, 0, 1, "flush_r2");
        tick();
        look(0, 7, 0, 0, 1, "flush_r7");
        look(1, 3, 32'hDEADBEEF, 0, 1, "flush_r3");
        tick();
        look(0, 8, 32'h55, 0, 1, "flush_dest_wr");
        look(1, 4, 32'h22, 0, 1, "flush_r4");
        tick();

        // r0 is hardwired.
        twr(0, 4);
        dwr(0, 4, 32'hFF);
        tick();
        look(0, 0, 0, 0, 1, "r0_p0");
        look(1, 0, 0, 0, 1, "r0_p1");
        tick();

        // Reset mid-operation clears pending tags and data.
        twr(11, 8);
        tick();
        look(0, 11, 0, 8, 0, "r11_pending");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        look(0, 11, 0, 0, 1, "midreset_r11");
        look(1, 3, 0, 0, 1, "midreset_r3");
        tick();
        @(negedge clk);
        stim_done = 1'b1;
    end

    initial begin
        fork
            wait (stim_done);
            #100000;
        join_any
        if (!stim_done) begin
            n_err++;
            $display("FAIL watchdog: got timeout, want stimulus complete");
        end
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover: got %0d unchecked, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
